apb_timer_mc: RTL and testbench



---
 rtl/apb_timer_mc_pkg.sv | 60 ++++++
 rtl/apb_timer_mc_if.sv | 23 ++
 rtl/apb_timer_mc_timer_channel.sv | 128 ++++++++++++
 rtl/apb_timer_mc.sv | 84 ++++++++
 tb/tb_apb_timer_mc.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_timer_mc_pkg.sv
// apb_timer_mc_pkg: register map, CTRL field positions and the packed
// CTRL/STATUS types shared by the timer top and its channels.
package apb_timer_mc_pkg;

    // Register index within a channel's 16-byte window (PADDR[3:2]).
    typedef enum logic [1:0] {
        REG_COUNT  = 2'd0,
        REG_CTRL   = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    // Bit positions of the CTRL fields in the 32-bit register word.
    localparam int CTRL_EN        = 0;
    localparam int CTRL_ONESHOT   = 1;
    localparam int CTRL_IE_OVF    = 2;
    localparam int CTRL_IE_CMP    = 3;
    localparam int CTRL_CLKSEL    = 4;
    localparam int CTRL_PRESC_LSB = 8;

    typedef struct packed {
        logic [7:0] presc;
        logic       clksel;
        logic       ie_cmp;
        logic       ie_ovf;
        logic       oneshot;
        logic       en;
    } ctrl_t;

    // Bit 0 = overflow, bit 1 = compare match.
    typedef struct packed {
        logic cmp;
        logic ovf;
    } status_t;

    function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
        ctrl_t c;
        c.en      = w[CTRL_EN];
        c.oneshot = w[CTRL_ONESHOT];
        c.ie_ovf  = w[CTRL_IE_OVF];
        c.ie_cmp  = w[CTRL_IE_CMP];
        c.clksel  = w[CTRL_CLKSEL];
        c.presc   = w[CTRL_PRESC_LSB +: 8];
        return c;
    endfunction

    // Unimplemented CTRL bits read back as zero.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w                       = '0;
        w[CTRL_EN]              = c.en;
        w[CTRL_ONESHOT]         = c.oneshot;
        w[CTRL_IE_OVF]          = c.ie_ovf;
        w[CTRL_IE_CMP]          = c.ie_cmp;
        w[CTRL_CLKSEL]          = c.clksel;
        w[CTRL_PRESC_LSB +: 8]  = c.presc;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_mc_if.sv
// apb_timer_mc_if: APB3 signal bundle between the bus master and the timer.
interface apb_timer_mc_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_mc_timer_channel.sv
// timer_channel: one timer channel -- COUNT/CTRL/CMP/STATUS registers,
// prescaler, compare/overflow handling and its irq pair.
// Optional feature macro: TIMER_CLK32_EN (CTRL.CLKSEL storage).
module timer_channel
    import apb_timer_mc_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        srst_ni,
    input  logic        tick32_i,
    input  logic        wr_en_i,
    input  reg_e        reg_sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  irq_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
    ctrl_t                ctrl_q, ctrl_d;
    status_t              status_q, status_d;
    logic [7:0]           pcnt_q, pcnt_d;
    logic                 src_tick;
    logic                 cnt_event;
    ctrl_t                ctrl_wr;

    assign src_tick = ctrl_q.clksel ? tick32_i : 1'b1;

`ifdef TIMER_CLK32_EN
    assign ctrl_wr = ctrl_from_word(wdata_i);
`else
    // Without the slow clock source CLKSEL is not stored and reads 0.
    always_comb begin
        ctrl_wr        = ctrl_from_word(wdata_i);
        ctrl_wr.clksel = 1'b0;
    end
`endif

    // Next state: W1C first so a same-cycle flag set wins, then count
    // event, then register writes which override the event for their target.
    always_comb begin
        count_d   = count_q;
        cmp_d     = cmp_q;
        ctrl_d    = ctrl_q;
        status_d  = status_q;
        pcnt_d    = pcnt_q;
        cnt_event = 1'b0;

        if (wr_en_i && reg_sel_i == REG_STATUS) begin
            if (wdata_i[0]) status_d.ovf = 1'b0;
            if (wdata_i[1]) status_d.cmp = 1'b0;
        end

        if (ctrl_q.en && src_tick) begin
            if (pcnt_q == ctrl_q.presc) begin
                pcnt_d    = '0;
                cnt_event = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end

        if (cnt_event) begin
            if (cmp_q != '0 && count_q == cmp_q) begin
                count_d      = '0;
                status_d.cmp = 1'b1;
                if (ctrl_q.oneshot) ctrl_d.en = 1'b0;
            end else if (count_q == '1) begin
                count_d      = '0;
                status_d.ovf = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        if (wr_en_i) begin
            case (reg_sel_i)
                REG_COUNT: begin
                    count_d = wdata_i[CNT_WIDTH-1:0];
                    pcnt_d  = '0;
                end
                REG_CTRL: begin
                    ctrl_d = ctrl_wr;
                    if (!ctrl_q.en && ctrl_wr.en) pcnt_d = '0;
                end
                REG_CMP: begin
                    cmp_d   = wdata_i[CNT_WIDTH-1:0];
                    count_d = '0;
                    pcnt_d  = '0;
                end
                default: ;
            endcase
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            count_q  <= '0;
            cmp_q    <= '0;
            ctrl_q   <= '0;
            status_q <= '0;
            pcnt_q   <= '0;
        end else begin
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            pcnt_q   <= pcnt_d;
        end
    end

    // Register read mux; narrow counters zero-extend to the bus width.
    always_comb begin
        rdata_o = '0;
        case (reg_sel_i)
            REG_COUNT:  rdata_o = 32'(count_q);
            REG_CTRL:   rdata_o = ctrl_to_word(ctrl_q);
            REG_CMP:    rdata_o = 32'(cmp_q);
            REG_STATUS: rdata_o = {30'b0, status_q};
            default:    rdata_o = '0;
        endcase
    end

    assign irq_o = {status_q.cmp & ctrl_q.ie_cmp, status_q.ovf & ctrl_q.ie_ovf};

endmodule

// File: rtl/apb_timer_mc.sv
// apb_timer_mc: multi-channel APB timer top -- address decode, read mux,
// clk32 synchroniser and one timer_channel per channel.
// Optional feature macro: TIMER_CLK32_EN (clk32 source per channel).
module apb_timer_mc
    import apb_timer_mc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_TIMERS       = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    clk32_i,
    apb_timer_mc_if.slave           apb,
    output logic [2*N_TIMERS-1:0]   irq_o
);

    logic                access;
    logic [3:0]          chan;
    reg_e                reg_sel;
    logic [N_TIMERS-1:0] ch_sel;
    logic                mapped;
    logic [31:0]         ch_rdata [N_TIMERS];
    logic [31:0]         rdata_mux;
    logic                tick32;
    logic                unused_bits;

    assign access  = apb.PSEL && apb.PENABLE;
    assign chan    = apb.PADDR[7:4];
    assign reg_sel = reg_e'(apb.PADDR[3:2]);
    assign mapped  = |ch_sel;

`ifdef TIMER_CLK32_EN
    logic [2:0] sync_q, sync_d;

    assign sync_d = {sync_q[1:0], clk32_i};
    // Rising-edge detect on the third stage gives a one-cycle tick.
    assign tick32 = sync_q[1] & ~sync_q[2];

    // Three-flop synchroniser for the asynchronous 32 kHz clock.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) sync_q <= '0;
        else          sync_q <= sync_d;
    end

    assign unused_bits = ^{apb.PADDR[APB_ADDR_WIDTH-1:8], apb.PADDR[1:0]};
`else
    assign tick32      = 1'b0;
    assign unused_bits = ^{apb.PADDR[APB_ADDR_WIDTH-1:8], apb.PADDR[1:0], clk32_i};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_TIMERS; gi++) begin : g_ch
            assign ch_sel[gi] = (chan == 4'(gi));

            timer_channel #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_ch (
                .clk_i     (HCLK),
                .srst_ni   (HRESETn),
                .tick32_i  (tick32),
                .wr_en_i   (access && apb.PWRITE && ch_sel[gi]),
                .reg_sel_i (reg_sel),
                .wdata_i   (apb.PWDATA),
                .rdata_o   (ch_rdata[gi]),
                .irq_o     (irq_o[2*gi +: 2])
            );
        end
    endgenerate

    // One-hot channel select keeps the read path free of out-of-range indexing.
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            if (ch_sel[i]) rdata_mux = rdata_mux | ch_rdata[i];
        end
    end

    assign apb.PRDATA  = (access && mapped) ? rdata_mux : 32'h0;
    assign apb.PSLVERR = access && !mapped;
    assign apb.PREADY  = 1'b1;

endmodule

// File: tb/tb_apb_timer_mc.sv
// tb_apb_timer_mc: scoreboard bench for apb_timer_mc (4 channels, 32-bit).
// Clk32 source checks run when TIMER_CLK32_EN is defined.
module tb_apb_timer_mc;

    localparam int N_TIMERS = 4;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  clk32;
    logic [2*N_TIMERS-1:0] irq;

    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   last_wr_cyc = 0;
    logic last_slverr;
    int   w;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    apb_timer_mc_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_timer_mc #(
        .APB_ADDR_WIDTH (12),
        .N_TIMERS       (N_TIMERS),
        .CNT_WIDTH      (32)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .clk32_i (clk32),
        .apb     (bus),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 ns after a rising edge; the write lands on the second edge.
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        bus.PWRITE  = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(posedge clk);
        #1;
        bus.PENABLE = 1'b1;
        #1;
        last_slverr = bus.PSLVERR;
        @(posedge clk);
        #1;
        last_wr_cyc = cyc;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        $display("[TB] WR addr=0x%03h data=0x%08h slverr=%0b", addr, data, last_slverr);
    endtask

    // Samples the access phase, then pops the expected value and compares.
    task automatic apb_read(input logic [11:0] addr);
        logic [31:0] rd;
        exp_t        e;
        bus.PADDR   = addr;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(posedge clk);
        #1;
        bus.PENABLE = 1'b1;
        #1;
        rd          = bus.PRDATA;
        last_slverr = bus.PSLVERR;
        @(posedge clk);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        $display("[TB] RD addr=0x%03h data=0x%08h slverr=%0b", addr, rd, last_slverr);
        e = sb_q.pop_front();
        check_val(e.tag, rd, e.exp);
    endtask

    task automatic rd_expect(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        apb_read(addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        clk32       = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        idle(3);
        rstn = 1'b1;

        // Reset state
        check_val("rst_irq", 32'(irq), 32'h0);
        check_val("rst_pready", {31'b0, bus.PREADY}, 32'h1);
        check_val("rst_idle_prdata", bus.PRDATA, 32'h0);
        check_val("rst_idle_pslverr", {31'b0, bus.PSLVERR}, 32'h0);
        rd_expect(12'h000, 32'h0, "rst_ch0_count");
        rd_expect(12'h004, 32'h0, "rst_ch0_ctrl");
        rd_expect(12'h008, 32'h0, "rst_ch0_cmp");
        rd_expect(12'h00C, 32'h0, "rst_ch0_status");
        check_val("mapped_pslverr", {31'b0, last_slverr}, 32'h0);

        // CH0 free-running compare, period 6 (counts 0..5)
        apb_write(12'h008, 32'd5);
        apb_write(12'h004, 32'h0000_000D);
        w = last_wr_cyc;
        check_val("ch0_irq_before_match", 32'(irq), 32'h0);
        for (int i = 0; i < 6; i++) begin
            rd_expect(12'h000, 32'((cyc + 1 - w) % 6), $sformatf("ch0_count_%0d", i));
            idle(3);
        end
        apb_write(12'h004, 32'h0000_000C);
        rd_expect(12'h000, 32'((last_wr_cyc - w) % 6), "ch0_count_frozen");
        rd_expect(12'h004, 32'h0000_000C, "ch0_ctrl");
        rd_expect(12'h00C, 32'h2, "ch0_status_cmp");
        check_val("ch0_irq_cmp_held", {30'b0, irq[1:0]}, 32'h2);
        apb_write(12'h00C, 32'h2);
        check_val("ch0_irq_cleared", {30'b0, irq[1:0]}, 32'h0);
        rd_expect(12'h00C, 32'h0, "ch0_status_w1c");

        // CH1 prescaler 3, compare 2: event every 4 cycles, flag at 12
        apb_write(12'h018, 32'd2);
        apb_write(12'h014, 32'h0000_0301);
        w = last_wr_cyc;
        for (int i = 0; i < 4; i++) begin
            rd_expect(12'h010, 32'(((cyc + 1 - w) / 4) % 3), $sformatf("ch1_count_%0d", i));
            rd_expect(12'h01C, ((cyc + 1 - w) >= 12) ? 32'h2 : 32'h0, $sformatf("ch1_status_%0d", i));
        end
        check_val("ch1_irq_masked", {30'b0, irq[3:2]}, 32'h0);
        apb_write(12'h014, 32'h0);

        // CH2 overflow from 0xFFFF_FFFE, interrupt masked then enabled
        apb_write(12'h028, 32'h0);
        apb_write(12'h020, 32'hFFFF_FFFE);
        apb_write(12'h024, 32'h0000_0001);
        w = last_wr_cyc;
        rd_expect(12'h020, 32'hFFFF_FFFE + 32'(cyc + 1 - w), "ch2_count_top");
        rd_expect(12'h020, 32'hFFFF_FFFE + 32'(cyc + 1 - w), "ch2_count_wrap");
        rd_expect(12'h02C, 32'h1, "ch2_status_ovf");
        check_val("ch2_irq_masked", {30'b0, irq[5:4]}, 32'h0);
        apb_write(12'h024, 32'h0000_0005);
        check_val("ch2_irq_ovf", {30'b0, irq[5:4]}, 32'h1);
        apb_write(12'h02C, 32'h1);
        check_val("ch2_irq_cleared", {30'b0, irq[5:4]}, 32'h0);
        apb_write(12'h024, 32'h0);

        // CH0 one-shot, compare 3
        apb_write(12'h008, 32'd3);
        apb_write(12'h004, 32'h0000_000F);
        idle(6);
        rd_expect(12'h004, 32'h0000_000E, "ch0_oneshot_en_cleared");
        rd_expect(12'h000, 32'h0, "ch0_oneshot_count");
        rd_expect(12'h00C, 32'h2, "ch0_oneshot_status");
        check_val("ch0_oneshot_irq", {30'b0, irq[1:0]}, 32'h2);
        // W1C landing on the match edge: the set wins
        apb_write(12'h004, 32'h0000_000F);
        idle(2);
        apb_write(12'h00C, 32'h2);
        rd_expect(12'h00C, 32'h2, "ch0_set_beats_w1c");
        rd_expect(12'h004, 32'h0000_000E, "ch0_oneshot_again");
        // CTRL write landing on the one-shot match edge: the write wins
        apb_write(12'h004, 32'h0000_000F);
        idle(2);
        apb_write(12'h004, 32'h0000_000F);
        rd_expect(12'h004, 32'h0000_000F, "ch0_ctrl_write_beats_oneshot");
        idle(4);
        apb_write(12'h004, 32'h0);
        apb_write(12'h00C, 32'h3);
        check_val("all_irq_clear", 32'(irq), 32'h0);

        // Unmapped channel 5
        rd_expect(12'h054, 32'h0, "unmapped_prdata");
        check_val("unmapped_rd_pslverr", {31'b0, last_slverr}, 32'h1);
        apb_write(12'h054, 32'h0000_FF1F);
        check_val("unmapped_wr_pslverr", {31'b0, last_slverr}, 32'h1);
        apb_write(12'h058, 32'h0000_0077);
        rd_expect(12'h014, 32'h0, "alias_ch1_ctrl");
        check_val("mapped_rd_pslverr", {31'b0, last_slverr}, 32'h0);
        rd_expect(12'h018, 32'd2, "alias_ch1_cmp");

        // CH3 count source select
`ifdef TIMER_CLK32_EN
        apb_write(12'h034, 32'h0000_0011);
        rd_expect(12'h034, 32'h0000_0011, "ch3_ctrl_clksel");
        rd_expect(12'h030, 32'h0, "ch3_no_tick");
        for (int i = 0; i < 3; i++) begin
            clk32 = 1'b1;
            idle(6);
            clk32 = 1'b0;
            idle(6);
            rd_expect(12'h030, 32'(i + 1), $sformatf("ch3_clk32_count_%0d", i));
        end
`else
        apb_write(12'h034, 32'h0000_0011);
        w = last_wr_cyc;
        rd_expect(12'h034, 32'h0000_0001, "ch3_ctrl_no_clksel");
        rd_expect(12'h030, 32'(cyc + 1 - w), "ch3_hclk_count");
`endif
        apb_write(12'h034, 32'h0);

        // Reset in the middle of counting
        apb_write(12'h004, 32'h0000_0001);
        idle(5);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        rd_expect(12'h000, 32'h0, "midrst_ch0_count");
        rd_expect(12'h004, 32'h0, "midrst_ch0_ctrl");
        rd_expect(12'h008, 32'h0, "midrst_ch0_cmp");
        check_val("midrst_irq", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
